jtag_master: RTL

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jtag_master.sv
// JTAG TAP master: runs TLR, IR/DR scan and run-test sequences on TCK/TMS/TDI and returns captured TDO.
// Each TCK period is 2*DIV_HALF clk cycles; a response is held until the consumer takes it.
module jtag_master #(
  parameter int DIV_HALF = 2,
  parameter int MAX_LEN  = 16
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [3:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP
  } state_t;

  state_t               state_q;
  logic [DW-1:0]        div_q;
  logic                 tck_q, tms_q, tdi_q;
  logic [15:0]          pat_q;
  logic [3:0]           pcnt_q, plast_q;
  logic [3:0]           len_q, bcnt_q;
  logic                 post_q, scan_q;
  logic [MAX_LEN-1:0]   data_q, cap_q, rsp_data_q;
  logic                 rsp_valid_q;

  // TMS pattern (LSB first) and last tick index of the leading part of each command
  logic [15:0] cmd_pat_d;
  logic [3:0]  cmd_last_d;
  always_comb begin
    cmd_pat_d  = 16'h0000;
    cmd_last_d = cmd_len;
    case (cmd_type)
      2'b00: begin cmd_pat_d = 16'h001F; cmd_last_d = 4'd5; end
      2'b01: begin cmd_pat_d = 16'h0003; cmd_last_d = 4'd3; end
      2'b10: begin cmd_pat_d = 16'h0001; cmd_last_d = 4'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_INIT;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      pat_q       <= 16'h001F;
      pcnt_q      <= 4'd0;
      plast_q     <= 4'd5;
      len_q       <= 4'd0;
      bcnt_q      <= 4'd0;
      post_q      <= 1'b0;
      scan_q      <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q <= S_PRE;
            div_q   <= '0;
            tck_q   <= 1'b0;
            pat_q   <= cmd_pat_d;
            tms_q   <= cmd_pat_d[0];
            tdi_q   <= 1'b0;
            pcnt_q  <= 4'd0;
            plast_q <= cmd_last_d;
            len_q   <= cmd_len;
            data_q  <= cmd_data;
            cap_q   <= '0;
            scan_q  <= cmd_type[0] ^ cmd_type[1];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            tck_q <= ~tck_q;
            if (!tck_q) begin
              if (state_q == S_SHIFT) cap_q[bcnt_q] <= TDO;
            end else begin
              // falling TCK edge: set up TMS/TDI for the next tick or finish
              case (state_q)
                S_SHIFT: begin
                  if (bcnt_q == len_q) begin
                    state_q <= S_POST;
                    post_q  <= 1'b0;
                    tms_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                  end else begin
                    bcnt_q <= bcnt_q + 4'd1;
                    data_q <= data_q >> 1;
                    tdi_q  <= data_q[1];
                    tms_q  <= ((bcnt_q + 4'd1) == len_q);
                  end
                end
                S_POST: begin
                  if (post_q) begin
                    state_q     <= S_RESP;
                    rsp_data_q  <= cap_q;
                    rsp_valid_q <= 1'b1;
                  end else begin
                    post_q <= 1'b1;
                    tms_q  <= 1'b0;
                  end
                end
                default: begin
                  if (pcnt_q == plast_q) begin
                    if (state_q == S_INIT) begin
                      state_q <= S_IDLE;
                    end else if (scan_q) begin
                      state_q <= S_SHIFT;
                      bcnt_q  <= 4'd0;
                      tms_q   <= (len_q == 4'd0);
                      tdi_q   <= data_q[0];
                    end else begin
                      state_q     <= S_RESP;
                      rsp_data_q  <= '0;
                      rsp_valid_q <= 1'b1;
                    end
                  end else begin
                    pcnt_q <= pcnt_q + 4'd1;
                    pat_q  <= pat_q >> 1;
                    tms_q  <= pat_q[1];
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule
